// File: rtl/ddr_req_scheduler.sv
// Arbitrates the capture-side write requester and the read-back requester onto the MIG DDR2 app_* interface.
// Define DDR_SCHED_WR_PRIORITY_EN for strict write priority instead of burst-limited round-robin.
module ddr_req_scheduler #(
    parameter int ADDR_WIDTH         = 27,
    parameter int DATA_WIDTH         = 128,
    parameter int MAX_BURST          = 8,
    parameter int MAX_RD_OUTSTANDING = 16
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    input  logic                                        init_calib_complete,
    input  logic                                        wr_req,
    input  logic [ADDR_WIDTH-1:0]                       wr_adx,
    input  logic [DATA_WIDTH-1:0]                       wr_data,
    output logic                                        wr_ack,
    input  logic                                        rd_req,
    input  logic [ADDR_WIDTH-1:0]                       rd_adx,
    output logic                                        rd_ack,
    output logic                                        app_en,
    output logic [2:0]                                  app_cmd,
    output logic [ADDR_WIDTH-1:0]                       app_addr,
    input  logic                                        app_rdy,
    output logic [DATA_WIDTH-1:0]                       app_wdf_data,
    output logic                                        app_wdf_wren,
    output logic                                        app_wdf_end,
    input  logic                                        app_wdf_rdy,
    input  logic                                        app_rd_data_valid,
    output logic [$clog2(MAX_RD_OUTSTANDING+1)-1:0]     rd_outstanding,
    output logic                                        busy
);

    localparam int CNT_W = $clog2(MAX_RD_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_WR,
        ISSUE_RD
    } state_t;

    state_t state;
    state_t next_state;

    logic wr_elig;
    logic rd_elig;
    logic grant_wr;
    logic grant_rd;
    logic cmd_acc;
    logic data_acc;
    logic cmd_done;
    logic data_done;

`ifndef DDR_SCHED_WR_PRIORITY_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    logic               last_wr;
    logic [BURST_W-1:0] burst_cnt;
    logic               keep_last;

    // burst_cnt == 0 only before the first grant, so the first tie goes to the write
    assign keep_last = (burst_cnt != '0) && (burst_cnt < BURST_W'(MAX_BURST));
`endif

    always_comb begin
        wr_elig  = init_calib_complete && wr_req;
        rd_elig  = init_calib_complete && rd_req &&
                   (rd_outstanding < CNT_W'(MAX_RD_OUTSTANDING));
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE) begin
`ifdef DDR_SCHED_WR_PRIORITY_EN
            grant_wr = wr_elig;
            grant_rd = rd_elig && !wr_req;
`else
            if (wr_elig && rd_elig) begin
                grant_wr = keep_last ? last_wr : !last_wr;
                grant_rd = !grant_wr;
            end else begin
                grant_wr = wr_elig;
                grant_rd = rd_elig;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    next_state = ISSUE_WR;
                end else if (grant_rd) begin
                    next_state = ISSUE_RD;
                end
            end
            ISSUE_WR: begin
                if ((cmd_done || cmd_acc) && (data_done || data_acc)) begin
                    next_state = IDLE;
                end
            end
            ISSUE_RD: begin
                if (app_rdy) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command and write data are handshaken independently; each drops once accepted
    always_comb begin
        app_en       = ((state == ISSUE_WR) && !cmd_done) || (state == ISSUE_RD);
        app_cmd      = (state == ISSUE_RD) ? 3'b001 : 3'b000;
        app_wdf_wren = (state == ISSUE_WR) && !data_done;
        app_wdf_end  = app_wdf_wren;
        busy         = (state != IDLE);
        cmd_acc      = app_en && app_rdy;
        data_acc     = app_wdf_wren && app_wdf_rdy;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            app_addr     <= '0;
            app_wdf_data <= '0;
            wr_ack       <= 1'b0;
            rd_ack       <= 1'b0;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
        end else begin
            wr_ack <= grant_wr;
            rd_ack <= grant_rd;
            if (grant_wr) begin
                app_addr     <= wr_adx;
                app_wdf_data <= wr_data;
            end else if (grant_rd) begin
                app_addr <= rd_adx;
            end
            if (grant_wr || grant_rd) begin
                cmd_done  <= 1'b0;
                data_done <= 1'b0;
            end else if (state == ISSUE_WR) begin
                if (cmd_acc) begin
                    cmd_done <= 1'b1;
                end
                if (data_acc) begin
                    data_done <= 1'b1;
                end
            end
        end
    end

`ifndef DDR_SCHED_WR_PRIORITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_wr   <= 1'b0;
            burst_cnt <= '0;
        end else if (grant_wr || grant_rd) begin
            last_wr <= grant_wr;
            if (grant_wr != last_wr) begin
                burst_cnt <= BURST_W'(1);
            end else if (burst_cnt < BURST_W'(MAX_BURST)) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end
        end
    end
`endif

    // Credits are reserved at grant time so the return buffer can never overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_outstanding <= '0;
        end else if (grant_rd && !app_rd_data_valid) begin
            rd_outstanding <= rd_outstanding + CNT_W'(1);
        end else if (app_rd_data_valid && !grant_rd && (rd_outstanding != '0)) begin
            rd_outstanding <= rd_outstanding - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ddr_req_scheduler.sv
// Bench for ddr_req_scheduler: transaction-level reference model compared every cycle, plus directed scenarios.
module tb_ddr_req_scheduler;

    localparam int AW  = 27;
    localparam int DW  = 128;
    localparam int MB  = 8;
    localparam int MRO = 16;
    localparam int CW  = $clog2(MRO + 1);

    logic          clk = 1'b0;
    logic          resetn;
    logic          init_calib_complete;
    logic          wr_req;
    logic [AW-1:0] wr_adx;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_adx;
    logic          rd_ack;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic          app_rd_data_valid;
    logic [CW-1:0] rd_outstanding;
    logic          busy;

    always #5 clk = ~clk;

    ddr_req_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .MAX_RD_OUTSTANDING(MRO)
    ) dut (
        .clk(clk), .resetn(resetn), .init_calib_complete(init_calib_complete),
        .wr_req(wr_req), .wr_adx(wr_adx), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_adx(rd_adx), .rd_ack(rd_ack),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
        .rd_outstanding(rd_outstanding), .busy(busy)
    );

    int tests;
    int fails;

    // Model: the transaction in flight (0 none, 1 write, 2 read), its pending halves, credits and grant history
    int            m_kind;
    bit            m_cmd_pend;
    bit            m_dat_pend;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_wr_ack;
    bit            m_rd_ack;
    int            m_credits;
    bit            hist[$];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic modelReset();
        m_kind     = 0;
        m_cmd_pend = 0;
        m_dat_pend = 0;
        m_addr     = '0;
        m_data     = '0;
        m_wr_ack   = 0;
        m_rd_ack   = 0;
        m_credits  = 0;
        hist.delete();
    endtask

    task automatic modelStep();
        bit we, re, gw, gr, last;
        int run;
        we = init_calib_complete && wr_req;
        re = init_calib_complete && rd_req && (m_credits < MRO);
        gw = 0;
        gr = 0;
        m_wr_ack = 0;
        m_rd_ack = 0;
        if (m_kind == 0) begin
`ifdef DDR_SCHED_WR_PRIORITY_EN
            gw = we;
            gr = re && !wr_req;
`else
            if (we && re) begin
                if (hist.size() == 0) begin
                    gw = 1;
                end else begin
                    last = hist[hist.size()-1];
                    run  = 0;
                    for (int i = hist.size() - 1; i >= 0; i--) begin
                        if (hist[i] != last) break;
                        run++;
                    end
                    gw = (run < MB) ? last : !last;
                end
                gr = !gw;
            end else begin
                gw = we;
                gr = re;
            end
`endif
            if (gw) begin
                m_kind = 1; m_cmd_pend = 1; m_dat_pend = 1;
                m_addr = wr_adx; m_data = wr_data; m_wr_ack = 1;
                hist.push_back(1'b1);
            end else if (gr) begin
                m_kind = 2; m_cmd_pend = 1;
                m_addr = rd_adx; m_rd_ack = 1;
                hist.push_back(1'b0);
            end
            if (hist.size() > 2 * MB) void'(hist.pop_front());
        end else if (m_kind == 1) begin
            if (app_rdy) m_cmd_pend = 0;
            if (app_wdf_rdy) m_dat_pend = 0;
            if (!m_cmd_pend && !m_dat_pend) m_kind = 0;
        end else begin
            if (app_rdy) m_kind = 0;
        end
        if (gr && !app_rd_data_valid) m_credits++;
        else if (app_rd_data_valid && !gr && m_credits > 0) m_credits--;
    endtask

    task automatic checkOutput();
        bit e_en, e_wren;
        e_en   = (m_kind == 1 && m_cmd_pend) || m_kind == 2;
        e_wren = (m_kind == 1) && m_dat_pend;
        check("wr_ack", DW'(wr_ack), DW'(m_wr_ack));
        check("rd_ack", DW'(rd_ack), DW'(m_rd_ack));
        check("app_en", DW'(app_en), DW'(e_en));
        check("app_wdf_wren", DW'(app_wdf_wren), DW'(e_wren));
        check("app_wdf_end", DW'(app_wdf_end), DW'(e_wren));
        check("busy", DW'(busy), DW'(m_kind != 0));
        check("rd_outstanding", DW'(rd_outstanding), DW'(m_credits));
        if (e_en) begin
            check("app_cmd", DW'(app_cmd), DW'((m_kind == 2) ? 3'b001 : 3'b000));
            check("app_addr", DW'(app_addr), DW'(m_addr));
        end
        if (e_wren) check("app_wdf_data", app_wdf_data, m_data);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic newWrite();
        wr_adx  = AW'($urandom);
        wr_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic newRead();
        rd_adx = AW'($urandom);
    endtask

    task automatic applyReset();
        @(negedge clk);
        resetn = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic drain();
        wr_req = 0;
        rd_req = 0;
        app_rdy = 1;
        app_wdf_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            app_rd_data_valid = (m_credits > 0);
            tick();
        end
        app_rd_data_valid = 0;
    endtask

    // One cycle of random requester and MIG behaviour; requesters move on after each ack
    task automatic applyStimulus();
        init_calib_complete = ($urandom_range(0, 19) != 0);
        app_rdy             = ($urandom_range(0, 3) != 0);
        app_wdf_rdy         = ($urandom_range(0, 3) != 0);
        app_rd_data_valid   = (m_credits > 0) && ($urandom_range(0, 2) == 0);
        if (m_wr_ack || !wr_req) begin
            newWrite();
            wr_req = ($urandom_range(0, 2) != 0);
        end
        if (m_rd_ack || !rd_req) begin
            newRead();
            rd_req = ($urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        int seen, en_cnt, wren_cnt, g, rd_cnt;
        bit got;
        tests = 0;
        fails = 0;
        resetn = 0;
        init_calib_complete = 0;
        wr_req = 0; rd_req = 0;
        wr_adx = '0; rd_adx = '0; wr_data = '0;
        app_rdy = 1; app_wdf_rdy = 1; app_rd_data_valid = 0;
        modelReset();
        repeat (3) @(negedge clk);
        check("reset app_en", DW'(app_en), DW'(1'b0));
        check("reset app_wdf_wren", DW'(app_wdf_wren), DW'(1'b0));
        check("reset busy", DW'(busy), DW'(1'b0));
        check("reset rd_outstanding", DW'(rd_outstanding), DW'(0));
        check("reset app_addr", DW'(app_addr), DW'(0));
        check("reset wr_ack", DW'(wr_ack), DW'(1'b0));
        resetn = 1;

        // Calibration gating
        wr_req = 1;
        wr_adx = 27'h1234567;
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (wr_ack || app_en) seen++;
        end
        check("calib gated", DW'(seen), DW'(0));
        init_calib_complete = 1;
        tick();
        check("calib ack", DW'(wr_ack), DW'(1'b1));
        check("calib addr", DW'(app_addr), DW'(27'h1234567));
        wr_req = 0;
        tick();

        // Split write acceptance: data held off for 5 cycles
        app_wdf_rdy = 0;
        wr_req = 1;
        newWrite();
        tick();
        wr_req = 0;
        en_cnt = 0;
        wren_cnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (app_en) en_cnt++;
            if (app_wdf_wren) wren_cnt++;
            app_wdf_rdy = (wren_cnt >= 6);
            tick();
        end
        app_wdf_rdy = 1;
        check("split app_en cycles", DW'(en_cnt), DW'(1));
        check("split wren cycles", DW'(wren_cnt), DW'(6));
        check("split idle", DW'(busy), DW'(1'b0));

        // Fairness with both requesters held
        applyReset();
        wr_req = 1;
        rd_req = 1;
        newWrite();
        newRead();
        g = 0;
        for (int i = 0; i < 200 && g < 32; i++) begin
            tick();
            if (wr_ack || rd_ack) begin
`ifdef DDR_SCHED_WR_PRIORITY_EN
                check("prio grant type", DW'(wr_ack), DW'(1'b1));
`else
                check("fair grant type", DW'(wr_ack), DW'(((g / MB) % 2) == 0));
`endif
                g++;
            end
            if (m_wr_ack) newWrite();
            if (m_rd_ack) newRead();
            app_rd_data_valid = (m_credits > 0);
        end
        check("fair grant count", DW'(g), DW'(32));
`ifdef DDR_SCHED_WR_PRIORITY_EN
        wr_req = 0;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (rd_ack) got = 1;
            app_rd_data_valid = (m_credits > 0);
        end
        check("prio read after wr drop", DW'(got), DW'(1'b1));
`endif
        drain();

        // Read credit limit
        applyReset();
        rd_req = 1;
        newRead();
        rd_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rd_ack) rd_cnt++;
            if (m_rd_ack) newRead();
        end
        check("credit ack count", DW'(rd_cnt), DW'(16));
        check("credit full", DW'(rd_outstanding), DW'(16));
        app_rd_data_valid = 1;
        tick();
        check("credit returned", DW'(rd_outstanding), DW'(15));
        tick();
        app_rd_data_valid = 0;
        check("credit grant+return ack", DW'(rd_ack), DW'(1'b1));
        check("credit grant+return count", DW'(rd_outstanding), DW'(15));
        newRead();
        tick();
        tick();
        check("credit refill ack", DW'(rd_ack), DW'(1'b1));
        check("credit refill count", DW'(rd_outstanding), DW'(16));
        drain();
        check("credit drained", DW'(rd_outstanding), DW'(0));

        // Reset during a stalled write
        rd_req = 1;
        newRead();
        tick();
        rd_req = 0;
        tick();
        app_rdy = 0;
        wr_req = 1;
        newWrite();
        tick();
        wr_req = 0;
        tick();
        #2;
        resetn = 0;
        modelReset();
        #1;
        check("async reset app_en", DW'(app_en), DW'(1'b0));
        check("async reset wren", DW'(app_wdf_wren), DW'(1'b0));
        check("async reset busy", DW'(busy), DW'(1'b0));
        check("async reset rd_outstanding", DW'(rd_outstanding), DW'(0));
        @(negedge clk);
        resetn = 1;
        app_rdy = 1;
        wr_req = 1;
        rd_req = 1;
        newWrite();
        newRead();
        tick();
        check("post-reset tie wr_ack", DW'(wr_ack), DW'(1'b1));
        check("post-reset tie rd_ack", DW'(rd_ack), DW'(1'b0));
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            tick();
        end
        init_calib_complete = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ddr_req_scheduler.md
# ddr_req_scheduler

Arbitrates the capture-side write requester and the read-back requester for the single MIG DDR2 user interface in `nexys4fpga`. It grants one request at a time using round-robin with a burst limit, then drives the MIG `app_*` command and write-data channels until the MIG accepts them. It reserves read-return credits so that outstanding reads never exceed the capacity of the return buffer drained by `consumer`. It issues nothing until `init_calib_complete` is high.

## Interface
Parameters:
- `ADDR_WIDTH`, 27, width of MIG `app_addr`
- `DATA_WIDTH`, 128, width of MIG write data (one BL8 on x16 DDR2)
- `MAX_BURST`, 8, maximum consecutive grants of one type while the other type is pending
- `MAX_RD_OUTSTANDING`, 16, read credits (depth of the return buffer)

Ports:
- `clk` in 1: the MIG `ui_clk` domain; every signal in this block is in this domain
- `resetn` in 1: asynchronous, active-low reset
- `init_calib_complete` in 1: MIG calibration done
- `wr_req` in 1: write request (level)
- `wr_adx` in ADDR_WIDTH: write address
- `wr_data` in DATA_WIDTH: write data
- `wr_ack` out 1: one-cycle pulse, write request captured
- `rd_req` in 1: read request (level)
- `rd_adx` in ADDR_WIDTH: read address
- `rd_ack` out 1: one-cycle pulse, read request captured
- `app_en` out 1: MIG command valid
- `app_cmd` out 3: 3'b000 write, 3'b001 read
- `app_addr` out ADDR_WIDTH: MIG command address
- `app_rdy` in 1: MIG command ready
- `app_wdf_data` out DATA_WIDTH: MIG write data
- `app_wdf_wren` out 1: MIG write-data valid
- `app_wdf_end` out 1: last beat of write data; identical to `app_wdf_wren`
- `app_wdf_rdy` in 1: MIG write-data ready
- `app_rd_data_valid` in 1: MIG read data returned; one pulse per read
- `rd_outstanding` out clog2(MAX_RD_OUTSTANDING+1): reserved read credits in use
- `busy` out 1: state is not IDLE

## Operation
- States: IDLE, ISSUE_WR, ISSUE_RD.
- IDLE, grant rules:
  - No grant while `init_calib_complete` is 0.
  - A read is eligible only when `rd_outstanding` < MAX_RD_OUTSTANDING.
  - If exactly one type is eligible, that type is granted.
  - If both types are eligible, the last-granted type wins while `burst_cnt` < MAX_BURST; otherwise the other type wins.
  - `burst_cnt` becomes 1 when the granted type differs from the last-granted type. Otherwise it increments, saturating at MAX_BURST.
- On a grant:
  - Capture the address (and data, for a write) into registers.
  - Pulse the matching ack.
  - Move to ISSUE_WR or ISSUE_RD.
  - A read grant increments `rd_outstanding` (credit reservation).
- ISSUE_WR:
  - `app_en`=1 with `app_cmd`=000, and `app_wdf_wren`=`app_wdf_end`=1, both from the first cycle.
  - The command is accepted on `app_en & app_rdy`; the data is accepted on `app_wdf_wren & app_wdf_rdy`. Each is dropped independently once accepted.
  - Return to IDLE in the cycle after both have been accepted.
- ISSUE_RD: `app_en`=1 with `app_cmd`=001 until `app_rdy`, then return to IDLE.
- `rd_outstanding` decrements on `app_rd_data_valid`. A simultaneous increment and decrement leaves it unchanged. It never wraps.
- `init_calib_complete` falling during ISSUE_*: the in-flight issue completes and no further grants are made.
- Reset values:
  - All outputs 0, including `rd_outstanding` and `busy`.
  - `burst_cnt`=0.
  - Last-granted type = read, so the first tie goes to the write.
  - State = IDLE.
  - Assertion of `resetn` mid-issue drops `app_en` and `app_wdf_wren` immediately.

## Timing
- `req` is high in IDLE in cycle N. The ack and the first `app_en` are high in cycle N+1.
- With `app_rdy` (and `app_wdf_rdy`) high, IDLE is reached in N+2 and the next grant is captured at the end of N+2. Peak rate is one request per 2 cycles.
- Requester rule: after seeing the ack, the requester must change or deassert `req`/`adx`/`data` by the following cycle.
- The scheduler ignores `req` while not in IDLE.
- Write with `app_rdy` high at cycle k and `app_wdf_rdy` high at cycle m: IDLE at max(k,m)+1.

## Configuration
- `DDR_SCHED_WR_PRIORITY_EN` defined: writes win every tie, `burst_cnt` is not used, and reads are granted only when `wr_req` is low.
- Not defined: round-robin with a MAX_BURST limit as described above.

## Test plan
- Calibration gating: `init_calib_complete`=0 with `wr_req`=1 for 100 cycles -> no `wr_ack`, `app_en`=0. Raise calibration -> `wr_ack` exactly one cycle later, `app_addr`=`wr_adx`.
- Split write acceptance: `app_rdy`=1 and `app_wdf_rdy` held 0 for 5 cycles -> `app_en` high for 1 cycle, `app_wdf_wren` high for 6 cycles, `busy` drops the cycle after data acceptance.
- Fairness (macro off, MAX_BURST=8): `wr_req` and `rd_req` both held continuously -> grants in the pattern 8 W, 8 R, repeating, starting with W.
- Credit limit: `app_rd_data_valid` held 0 with 20 reads requested -> exactly 16 `rd_ack`s, `rd_outstanding`=16. A single `app_rd_data_valid` pulse -> one more `rd_ack`. A simultaneous grant and data-valid pulse keeps the count constant.
- Reset mid-issue: deassert `resetn` in ISSUE_WR with `app_rdy`=0 -> `app_en`, `app_wdf_wren`, `busy`, `rd_outstanding` all 0 asynchronously. After release, the first tie is granted to a write.
- Macro on: both requests held -> only writes are granted. Drop `wr_req` -> a read is granted 1 cycle after IDLE.
